// File: rtl/game_timer.sv
// game_timer: single-clock seed counter and programmable game timer.
// A prescaler derives the timing tick from clk_50M; the FSM selects between
// free-running seed counting and one-shot / periodic tick timing.
module game_timer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 2_000,
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic             i_SeedEn,
  input  logic             i_Start,
  input  logic             i_Periodic,
  input  logic             i_Stop,
  output logic [WIDTH-1:0] o_Count,
  output logic             o_Tick,
  output logic             o_Done,
  output logic             o_Expired,
  output logic             o_Busy
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  // Guard keeps the prescaler at least one bit wide even for a bad DIV,
  // so the elaboration error below is what gets reported.
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]    PMAX      = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_LAST  = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] CNT_FINAL = WIDTH'(TIMEOUT);

  // Parameter sanity checks at elaboration time
  if (DIV < 2) begin : g_bad_div
    $error("game_timer: CLK_HZ/TICK_HZ must be >= 2");
  end
  if (TIMEOUT == 0) begin : g_bad_to_zero
    $error("game_timer: TIMEOUT must be >= 1");
  end
  if (64'(TIMEOUT) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_to_wide
    $error("game_timer: TIMEOUT does not fit in WIDTH bits");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEED    = 2'd1,
    ST_TIMING  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic [PW-1:0]   presc_nxt;
  logic            tick_q;
  logic            periodic_q;
  logic [WIDTH-1:0] count;
  logic            done_q;
  logic            expired_q;
  logic            busy_q;

  // Next prescaler value: wraps DIV-1 -> 0 (DIV need not be a power of two)
  always_comb begin
    presc_nxt = (presc == PMAX) ? '0 : presc + PW'(1);
  end

  // Free-running prescaler; tick is registered so it is high exactly while presc==DIV-1
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else if (i_Start) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else begin
      presc  <= presc_nxt;
      tick_q <= (presc_nxt == PMAX);
    end
  end

  // Mode FSM with count and registered status outputs
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
      expired_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_Start) begin
        // Start (or restart) always wins; a restart never reports done
        state      <= ST_TIMING;
        count      <= '0;
        periodic_q <= i_Periodic;
        busy_q     <= 1'b1;
        expired_q  <= 1'b0;
      end else if (i_Stop) begin
        // Abort: count is left as-is for inspection
        state     <= ST_IDLE;
        busy_q    <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // Seed counting starts on the first enabled clock
            if (i_SeedEn) begin
              state <= ST_SEED;
              count <= count + WIDTH'(1);
            end
          end
          ST_SEED: begin
            // Dropping the enable freezes the seed for the dealer
            if (i_SeedEn) count <= count + WIDTH'(1);
            else          state <= ST_IDLE;
          end
          ST_TIMING: begin
            if (tick_q) begin
              if (count == CNT_LAST) begin
                done_q <= 1'b1;
                if (periodic_q) begin
                  count <= '0;
                end else begin
                  count     <= CNT_FINAL;
                  state     <= ST_EXPIRED;
                  busy_q    <= 1'b0;
                  expired_q <= 1'b1;
                end
              end else begin
                count <= count + WIDTH'(1);
              end
            end
          end
          ST_EXPIRED: begin
            // Hold TIMEOUT until restarted or stopped
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_Count   = count;
  assign o_Tick    = tick_q;
  assign o_Done    = done_q;
  assign o_Expired = expired_q;
  assign o_Busy    = busy_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with DIV=10, WIDTH=4, TIMEOUT=5.
module tb_game_timer;

  localparam int W = 4;

  logic         clk_50M;
  logic         i_Reset;
  logic         i_SeedEn;
  logic         i_Start;
  logic         i_Periodic;
  logic         i_Stop;
  logic [W-1:0] o_Count;
  logic         o_Tick;
  logic         o_Done;
  logic         o_Expired;
  logic         o_Busy;

  int errors = 0;
  int checks = 0;

  game_timer #(
    .CLK_HZ (10),
    .TICK_HZ(1),
    .WIDTH  (W),
    .TIMEOUT(5)
  ) dut (
    .clk_50M   (clk_50M),
    .i_Reset   (i_Reset),
    .i_SeedEn  (i_SeedEn),
    .i_Start   (i_Start),
    .i_Periodic(i_Periodic),
    .i_Stop    (i_Stop),
    .o_Count   (o_Count),
    .o_Tick    (o_Tick),
    .o_Done    (o_Done),
    .o_Expired (o_Expired),
    .o_Busy    (o_Busy)
  );

  initial clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  // Advance n rising edges, then settle 1 time unit past the last edge
  task automatic step(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_SeedEn   = 1'($urandom_range(0, 1));
      i_Start    = 1'($urandom_range(0, 1));
      i_Periodic = 1'($urandom_range(0, 1));
      i_Stop     = 1'($urandom_range(0, 1));
      step(1);
    end
    checks++;
    if ({o_Count, o_Tick, o_Done, o_Expired, o_Busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000", {o_Count, o_Tick, o_Done, o_Expired, o_Busy});
    end
    i_Reset = 1'b0; i_SeedEn = 1'b0; i_Start = 1'b0; i_Periodic = 1'b0; i_Stop = 1'b0;
    step(1);
    checks++;
    if ({o_Count, o_Busy, o_Expired} !== 6'd0) begin
      errors++;
      $display("FAIL reset_idle_hold: got count=%0d busy=%b exp=%b expected 0 0 0", o_Count, o_Busy, o_Expired);
    end
  endtask

  task automatic test_seed();
    i_SeedEn = 1'b1;
    step(16);
    checks++;
    if (o_Count !== 4'd0) begin
      errors++;
      $display("FAIL seed_wrap: got %0d expected 0", o_Count);
    end
    step(4);
    checks++;
    if (o_Count !== 4'd4) begin
      errors++;
      $display("FAIL seed_20: got %0d expected 4", o_Count);
    end
    i_SeedEn = 1'b0;
    step(6);
    checks++;
    if (o_Count !== 4'd4 || o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL seed_freeze: got count=%0d busy=%b expected 4 0", o_Count, o_Busy);
    end
  endtask

  task automatic test_oneshot();
    i_Start = 1'b1; i_Periodic = 1'b0;
    step(1);
    i_Start = 1'b0;
    checks++;
    if (o_Count !== 4'd0 || o_Busy !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_start: got count=%0d busy=%b expected 0 1", o_Count, o_Busy);
    end
    step(8);
    checks++;
    if (o_Tick !== 1'b0) begin
      errors++;
      $display("FAIL tick_early: got %b expected 0", o_Tick);
    end
    step(1);
    checks++;
    if (o_Tick !== 1'b1 || o_Count !== 4'd0) begin
      errors++;
      $display("FAIL tick_first: got tick=%b count=%0d expected 1 0", o_Tick, o_Count);
    end
    step(1);
    checks++;
    if (o_Count !== 4'd1 || o_Tick !== 1'b0) begin
      errors++;
      $display("FAIL tick_count: got count=%0d tick=%b expected 1 0", o_Count, o_Tick);
    end
    step(39);
    checks++;
    if (o_Done !== 1'b0 || o_Count !== 4'd4) begin
      errors++;
      $display("FAIL oneshot_pre: got done=%b count=%0d expected 0 4", o_Done, o_Count);
    end
    step(1);
    checks++;
    if (o_Done !== 1'b1 || o_Count !== 4'd5 || o_Expired !== 1'b1 || o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_done: got done=%b count=%0d exp=%b busy=%b expected 1 5 1 0",
               o_Done, o_Count, o_Expired, o_Busy);
    end
    step(1);
    checks++;
    if (o_Done !== 1'b0 || o_Expired !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_pulse: got done=%b exp=%b expected 0 1", o_Done, o_Expired);
    end
    i_SeedEn = 1'b1;
    step(5);
    i_SeedEn = 1'b0;
    checks++;
    if (o_Count !== 4'd5 || o_Expired !== 1'b1) begin
      errors++;
      $display("FAIL expired_seed_ignored: got count=%0d exp=%b expected 5 1", o_Count, o_Expired);
    end
    i_Stop = 1'b1;
    step(1);
    i_Stop = 1'b0;
    checks++;
    if (o_Expired !== 1'b0 || o_Busy !== 1'b0 || o_Count !== 4'd5) begin
      errors++;
      $display("FAIL expired_stop: got exp=%b busy=%b count=%0d expected 0 0 5", o_Expired, o_Busy, o_Count);
    end
  endtask

  task automatic test_periodic();
    i_Start = 1'b1; i_Periodic = 1'b1;
    step(1);
    i_Start = 1'b0; i_Periodic = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(1);
      checks++;
      if (o_Done !== 1'b0 || o_Count !== 4'd0 || o_Busy !== 1'b1) begin
        errors++;
        $display("FAIL periodic_begin%0d: got done=%b count=%0d busy=%b expected 0 0 1", k, o_Done, o_Count, o_Busy);
      end
      step(48);
      checks++;
      if (o_Done !== 1'b0 || o_Count !== 4'd4) begin
        errors++;
        $display("FAIL periodic_pre%0d: got done=%b count=%0d expected 0 4", k, o_Done, o_Count);
      end
      step(1);
      checks++;
      if (o_Done !== 1'b1 || o_Count !== 4'd0 || o_Busy !== 1'b1 || o_Expired !== 1'b0) begin
        errors++;
        $display("FAIL periodic_done%0d: got done=%b count=%0d busy=%b exp=%b expected 1 0 1 0",
                 k, o_Done, o_Count, o_Busy, o_Expired);
      end
    end
  endtask

  task automatic test_stop();
    bit saw_done;
    // Restart from inside a periodic run, now one-shot
    i_Start = 1'b1; i_Periodic = 1'b0;
    step(1);
    i_Start = 1'b0;
    step(30);
    checks++;
    if (o_Count !== 4'd3 || o_Busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_pre: got count=%0d busy=%b expected 3 1", o_Count, o_Busy);
    end
    i_Stop = 1'b1;
    step(1);
    i_Stop = 1'b0;
    checks++;
    if (o_Busy !== 1'b0 || o_Count !== 4'd3 || o_Done !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: got busy=%b count=%0d done=%b expected 0 3 0", o_Busy, o_Count, o_Done);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (o_Done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || o_Count !== 4'd3) begin
      errors++;
      $display("FAIL stop_no_done: got saw_done=%b count=%0d expected 0 3", saw_done, o_Count);
    end
    i_Start = 1'b1; i_Stop = 1'b1;
    step(1);
    i_Start = 1'b0; i_Stop = 1'b0;
    checks++;
    if (o_Busy !== 1'b1 || o_Count !== 4'd0) begin
      errors++;
      $display("FAIL start_stop_same: got busy=%b count=%0d expected 1 0", o_Busy, o_Count);
    end
    step(10);
    checks++;
    if (o_Count !== 4'd1) begin
      errors++;
      $display("FAIL start_stop_tick: got %0d expected 1", o_Count);
    end
  endtask

  task automatic test_reset_mid();
    step(10);
    checks++;
    if (o_Count !== 4'd2 || o_Busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got count=%0d busy=%b expected 2 1", o_Count, o_Busy);
    end
    i_Reset = 1'b1;
    step(1);
    i_Reset = 1'b0;
    checks++;
    if ({o_Count, o_Tick, o_Done, o_Expired, o_Busy} !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got %b expected 00000000", {o_Count, o_Tick, o_Done, o_Expired, o_Busy});
    end
    i_Start = 1'b1;
    step(1);
    i_Start = 1'b0;
    step(49);
    checks++;
    if (o_Done !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart_pre: got done=%b expected 0", o_Done);
    end
    step(1);
    checks++;
    if (o_Done !== 1'b1 || o_Count !== 4'd5 || o_Expired !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart_done: got done=%b count=%0d exp=%b expected 1 5 1", o_Done, o_Count, o_Expired);
    end
  endtask

  task automatic test_back_to_back();
    // Restart straight out of EXPIRED
    i_Start = 1'b1;
    step(1);
    i_Start = 1'b0;
    checks++;
    if (o_Expired !== 1'b0 || o_Busy !== 1'b1 || o_Count !== 4'd0 || o_Done !== 1'b0) begin
      errors++;
      $display("FAIL expired_restart: got exp=%b busy=%b count=%0d done=%b expected 0 1 0 0",
               o_Expired, o_Busy, o_Count, o_Done);
    end
  endtask

  initial begin
    i_Reset = 1'b1; i_SeedEn = 1'b0; i_Start = 1'b0; i_Periodic = 1'b0; i_Stop = 1'b0;
    #2;
    test_reset();
    test_seed();
    test_oneshot();
    test_periodic();
    test_stop();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
